// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM, valid/ready output register.
// Define UART_RX_GLITCH_FILTER_EN to add a 3-sample majority filter on the synchronized line.
module uart_rx #(
  parameter int    BYTESIZE = 8,
  parameter string PARITY   = "NONE",
  parameter int    STOPSIZE = 1,
  parameter int    N_BIT    = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                uart_rxd,
  output logic [BYTESIZE-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ready,
  output logic                err_parity,
  output logic                err_frame,
  output logic                err_overrun,
  output logic                busy
);

  localparam bit PAR_EN  = (PARITY != "NONE");
  localparam bit PAR_ODD = (PARITY == "ODD");
  localparam int CW      = $clog2(N_BIT);
  localparam int BMAX    = (BYTESIZE > STOPSIZE) ? BYTESIZE : STOPSIZE;
  localparam int BW      = (BMAX > 1) ? $clog2(BMAX) : 1;

  localparam logic [CW-1:0] CNT_MID  = CW'(N_BIT / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_BIT - 1);
  localparam logic [BW-1:0] BIT_DATA_LAST = BW'(BYTESIZE - 1);
  localparam logic [BW-1:0] BIT_STOP_LAST = BW'(STOPSIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0] sync_q;
  logic       rxs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], uart_rxd};
    end
  end

`ifdef UART_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
    end
  end

  // Majority of three consecutive samples: a lone 1-cycle pulse never wins.
  assign rxs = (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign rxs = sync_q[1];
`endif

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [BYTESIZE-1:0] shift_q, shift_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;
  logic                rxs_prev_q;
  logic [BYTESIZE-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                err_parity_q, err_parity_d;
  logic                err_frame_q, err_frame_d;
  logic                err_overrun_q, err_overrun_d;
  logic                par_exp;

  assign par_exp = (^shift_q) ^ PAR_ODD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      perr_q        <= 1'b0;
      ferr_q        <= 1'b0;
      rxs_prev_q    <= 1'b1;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      err_parity_q  <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      perr_q        <= perr_d;
      ferr_q        <= ferr_d;
      rxs_prev_q    <= rxs;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      err_parity_q  <= err_parity_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_d         = bit_q;
    shift_d       = shift_q;
    perr_d        = perr_q;
    ferr_d        = ferr_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    err_parity_d  = err_parity_q;
    err_frame_d   = err_frame_q;
    err_overrun_d = 1'b0;

    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        // The detection cycle counts as baud tick 0, so START begins at tick 1.
        if (!rxs && rxs_prev_q) begin
          state_d = S_START;
          cnt_d   = CW'(1);
        end
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MID) begin
          cnt_d = '0;
          if (rxs) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[BYTESIZE-1:1]};
          if (bit_q == BIT_DATA_LAST) begin
            bit_d   = '0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          perr_d  = (rxs != par_exp);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_STOP_LAST) begin
            bit_d         = '0;
            state_d       = S_IDLE;
            rx_data_d     = shift_q;
            err_parity_d  = perr_q;
            err_frame_d   = ferr_q | ~rxs;
            rx_valid_d    = 1'b1;
            err_overrun_d = rx_valid_q & ~rx_ready;
          end else begin
            bit_d  = bit_q + 1'b1;
            ferr_d = ferr_q | ~rxs;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign err_parity  = err_parity_q;
  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx (8 data bits, ODD parity, 1 stop, 5 clocks/bit).
module tb_uart_rx;

  localparam int N_BIT = 5;
`ifdef UART_RX_GLITCH_FILTER_EN
  localparam int FILT = 1;
`else
  localparam int FILT = 0;
`endif
  // Pin fall -> rx_valid visible: sync + half bit + 10 further bits + load.
  localparam int LAT = 2 + FILT + N_BIT / 2 + 10 * N_BIT + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       err_parity;
  logic       err_frame;
  logic       err_overrun;
  logic       busy;

  uart_rx #(
    .BYTESIZE(8),
    .PARITY  ("ODD"),
    .STOPSIZE(1),
    .N_BIT   (N_BIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .err_parity (err_parity),
    .err_frame  (err_frame),
    .err_overrun(err_overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic       ep;
    logic       ef;
  } ev_t;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  ev_t  ev_q[$];
  ev_t  exp_q[$];
  int   ovr_cnt = 0;
  int   ovr_cyc = -1;
  bit   busy_seen = 1'b0;
  logic valid_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && valid_prev !== 1'b1) begin
      ev_t e;
      e.cyc = cyc;
      e.d   = rx_data;
      e.ep  = err_parity;
      e.ef  = err_frame;
      ev_q.push_back(e);
    end
    if (err_overrun === 1'b1) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
    valid_prev = rx_valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame; the expected character comes from the bit list, not the DUT.
  task automatic send_frame(input logic [7:0] d, input bit flip, input bit stop_bit);
    logic [10:0] bits;
    int          ones;
    ev_t         e;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    bits  = {stop_bit, (((ones % 2) == 0) ^ flip), d, 1'b0};
    e.cyc = cyc + LAT;
    e.d   = d;
    e.ep  = flip;
    e.ef  = !stop_bit;
    exp_q.push_back(e);
    for (int i = 0; i < 11; i++) begin
      uart_rxd = bits[i];
      repeat (N_BIT) @(posedge clk);
      #1;
    end
  endtask

  task automatic check_frames(input string tag);
    chk($sformatf("%s count", tag), ev_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < ev_q.size(); i++) begin
      chk($sformatf("%s[%0d] data", tag, i), ev_q[i].d, exp_q[i].d);
      chk($sformatf("%s[%0d] err_parity", tag, i), ev_q[i].ep, exp_q[i].ep);
      chk($sformatf("%s[%0d] err_frame", tag, i), ev_q[i].ef, exp_q[i].ef);
      chk($sformatf("%s[%0d] valid_cycle", tag, i), ev_q[i].cyc, exp_q[i].cyc);
    end
    ev_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] hello[5];
    logic [7:0] rd;
    bit         rflip;
    int         gap;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    rst = 1'b1; uart_rxd = 1'b1; rx_ready = 1'b1;
    idle(3);
    chk("reset rx_data", rx_data, 0);
    chk("reset rx_valid", rx_valid, 0);
    chk("reset err_parity", err_parity, 0);
    chk("reset err_frame", err_frame, 0);
    chk("reset err_overrun", err_overrun, 0);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    idle(10);
    ev_q.delete();
    ovr_cnt = 0;

    // Hello, back to back with rx_ready held high
    for (int i = 0; i < 5; i++) send_frame(hello[i], 1'b0, 1'b1);
    idle(10);
    check_frames("hello");
    chk("hello overrun", ovr_cnt, 0);
    chk("hello busy_idle", busy, 0);

    // Randomized characters, parity errors and idle gaps
    for (int i = 0; i < 8; i++) begin
      rd    = 8'($urandom_range(0, 255));
      rflip = 1'($urandom_range(0, 1));
      gap   = $urandom_range(0, 3);
      idle(gap);
      send_frame(rd, rflip, 1'b1);
    end
    idle(10);
    check_frames("random");

    // Wrong parity on 'T'
    send_frame(8'h54, 1'b1, 1'b1);
    idle(10);
    check_frames("parity_T");

    // Stop bit low, then break for 40 bit times
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40 * N_BIT) @(posedge clk);
    #1;
    check_frames("break");
    uart_rxd = 1'b1;
    idle(20);
    chk("break quiet", ev_q.size(), 0);

    // Overrun with rx_ready low
    rx_ready = 1'b0;
    ovr_cnt  = 0;
    send_frame(8'h41, 1'b0, 1'b1);
    send_frame(8'h42, 1'b0, 1'b1);
    idle(10);
    chk("overrun pulses", ovr_cnt, 1);
    chk("overrun cycle", ovr_cyc, exp_q[1].cyc);
    chk("overrun valid_rises", ev_q.size(), 1);
    chk("overrun rx_data", rx_data, 8'h42);
    chk("overrun rx_valid", rx_valid, 1);
    chk("overrun flag_low", err_overrun, 0);
    ev_q.delete();
    exp_q.delete();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    chk("ready clears valid", rx_valid, 0);
    rx_ready = 1'b1;
    idle(5);

    // Single-cycle glitch on an idle line
    busy_seen = 1'b0;
    uart_rxd  = 1'b0;
    idle(1);
    uart_rxd  = 1'b1;
    idle(20);
    chk("glitch busy_seen", busy_seen, (FILT == 0) ? 1 : 0);
    chk("glitch busy_now", busy, 0);
    chk("glitch no_valid", ev_q.size(), 0);

    // Reset during data bit 3 of 0x5A
    rd = 8'h5A;
    uart_rxd = 1'b0;
    idle(N_BIT);
    for (int i = 0; i < 3; i++) begin
      uart_rxd = rd[i];
      idle(N_BIT);
    end
    uart_rxd = rd[3];
    idle(2);
    chk("pre_reset busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("midreset rx_data", rx_data, 0);
    chk("midreset rx_valid", rx_valid, 0);
    chk("midreset err_parity", err_parity, 0);
    chk("midreset err_frame", err_frame, 0);
    chk("midreset err_overrun", err_overrun, 0);
    chk("midreset busy", busy, 0);
    uart_rxd = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(10);
    chk("after_reset no_valid", ev_q.size(), 0);
    ev_q.delete();
    exp_q.delete();
    send_frame(8'h55, 1'b0, 1'b1);
    idle(10);
    check_frames("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
